// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
//   Moore-style control FSM for a multi-cycle RV32-like datapath. It sequences
//   fetch / decode / execute / memory / writeback. It traps on an illegal
//   opcode or on a memory access that stays not-ready for too long. It also
//   counts retired instructions.
//
// Configuration macro:
//   MULTI_CYCLE_CTRL_JAL_EN - when defined, opcode 1101111 (JAL) is executed
//                             through a dedicated JAL state. When undefined,
//                             that opcode is illegal and traps.
//
// Parameters:
//   MEM_TIMEOUT - max consecutive not-ready cycles per memory access (0 = off)
//   CNT_W       - width of the retired-instruction counter
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   op              instruction opcode field
//   zero            ALU zero flag (branch condition)
//   mem_ready       memory completes the current access this cycle
//   mem_req/mem_write/adr_src       memory interface control
//   ir_write/pc_write/reg_write     architectural state write enables
//   alu_src_a/alu_src_b/alu_op      ALU operand and operation select
//   imm_src, result_src             immediate format / result mux select
//   trap, trap_cause                halted flag and reason (01 illegal, 10 timeout)
//   state                           current state code
//   retired                         completed-instruction count
// -----------------------------------------------------------------------------
module multi_cycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MULTI_CYCLE_CTRL_JAL_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // The wait counter only has to reach MEM_TIMEOUT; keep at least one bit.
  localparam int                WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V  = WAIT_W'(MEM_TIMEOUT);
  localparam logic              TIMEOUT_EN = (MEM_TIMEOUT > 0);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
`ifdef MULTI_CYCLE_CTRL_JAL_EN
    S_JAL      = 4'd11,
`endif
    S_TRAP     = 4'd15
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_next_s;
  logic [1:0]        trap_cause_r;
  logic [1:0]        cause_next_s;
  logic [CNT_W-1:0]  retired_r;
  logic              retire_s;
  logic              timeout_s;

  // Memory access has been stalled for the full budget and is still not ready.
  assign timeout_s = TIMEOUT_EN && (wait_cnt_r == TIMEOUT_V) && !mem_ready;

  // State, wait counter, trap cause and retired counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      wait_cnt_r   <= '0;
      trap_cause_r <= 2'b00;
      retired_r    <= '0;
    end else begin
      state_r      <= state_next_s;
      wait_cnt_r   <= wait_next_s;
      trap_cause_r <= cause_next_s;
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Next-state logic. The wait counter only counts while a memory state is
  // held waiting. Every other path, including entry into a memory state and
  // any ready cycle, leaves it cleared.
  always_comb begin
    state_next_s = state_r;
    wait_next_s  = '0;
    cause_next_s = trap_cause_r;
    retire_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        state_next_s = S_FETCH;
      end
      S_FETCH: begin
        if (timeout_s) begin
          state_next_s = S_TRAP;
          cause_next_s = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          state_next_s = S_DECODE;
        end else begin
          wait_next_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
          OP_RTYPE:          state_next_s = S_EXECR;
          OP_ITYPE:          state_next_s = S_EXECI;
          OP_BRANCH:         state_next_s = S_BEQ;
`ifdef MULTI_CYCLE_CTRL_JAL_EN
          OP_JAL:            state_next_s = S_JAL;
`endif
          default: begin
            state_next_s = S_TRAP;
            cause_next_s = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LOAD) begin
          state_next_s = S_MEMREAD;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        if (timeout_s) begin
          state_next_s = S_TRAP;
          cause_next_s = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          state_next_s = S_MEMWB;
        end else begin
          wait_next_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      S_MEMWB: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_MEMWRITE: begin
        if (timeout_s) begin
          state_next_s = S_TRAP;
          cause_next_s = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          state_next_s = S_FETCH;
          retire_s     = 1'b1;
        end else begin
          wait_next_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      S_EXECR, S_EXECI: begin
        state_next_s = S_ALUWB;
      end
      S_ALUWB: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_BEQ: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
`ifdef MULTI_CYCLE_CTRL_JAL_EN
      S_JAL: begin
        state_next_s = S_ALUWB;
      end
`endif
      S_TRAP: begin
        state_next_s = S_TRAP;
      end
      default: begin
        // Unused encodings restart the sequence cleanly.
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Moore output decode. FETCH write enables follow mem_ready. BEQ pc_write
  // follows zero.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    trap       = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
`ifdef MULTI_CYCLE_CTRL_JAL_EN
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
`endif
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        trap = 1'b0;
      end
    endcase
  end

  // Immediate format depends only on the opcode, independent of state.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
`ifdef MULTI_CYCLE_CTRL_JAL_EN
      OP_JAL:    imm_src = 2'b11;
`endif
      default:   imm_src = 2'b00;
    endcase
  end

  assign trap_cause = trap_cause_r;
  assign state      = state_r;
  assign retired    = retired_r;

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max consecutive not-ready cycles per memory access; 0 disables timeout.
REQ-002 SHALL have parameter CNT_W, default 32: width of retired-instruction counter.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, ports clk and rst; all state changes on rising clk.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- op  in  7  instruction opcode field
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  request is a write
- adr_src  out  1  0=PC, 1=ALU result address
- ir_write  out  1  latch instruction register
- pc_write  out  1  update PC
- reg_write  out  1  register file write
- alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
- alu_op  out  2  00=add, 01=sub/compare, 10=funct decode
- imm_src  out  2  immediate format
- result_src  out  2  00=ALU out reg, 01=mem data, 10=ALU result
- trap  out  1  controller halted
- trap_cause  out  2  01=illegal opcode, 10=memory timeout
- state  out  4  current state code
- retired  out  CNT_W  completed-instruction count

Function
REQ-005 SHALL be a Moore FSM with codes IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECR=7, EXECI=8, ALUWB=9, BEQ=10, JAL=11, TRAP=15; all outputs not listed for a state are 0.
REQ-006 IDLE: all outputs 0; next FETCH unconditionally.
REQ-007 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready; next DECODE when mem_ready, else stay.
REQ-008 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00; next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, other->TRAP with trap_cause=01.
REQ-009 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; next MEMREAD for op 0000011, else MEMWRITE.
REQ-010 MEMREAD: mem_req=1, adr_src=1; next MEMWB on mem_ready. MEMWB: result_src=01, reg_write=1; next FETCH.
REQ-011 MEMWRITE: mem_req=1, mem_write=1, adr_src=1; next FETCH on mem_ready.
REQ-012 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. EXECI: same with alu_src_b=01. Both next ALUWB.
REQ-013 ALUWB: result_src=00, reg_write=1; next FETCH.
REQ-014 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero; next FETCH.
REQ-015 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; next ALUWB.
REQ-016 imm_src SHALL be combinational from op in every state: 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-017 Wait counter SHALL clear on entry to FETCH/MEMREAD/MEMWRITE and on mem_ready=1; increment each cycle in those states with mem_ready=0.
REQ-018 When MEM_TIMEOUT>0, wait counter==MEM_TIMEOUT and mem_ready=0 in a memory state, next state SHALL be TRAP with trap_cause=10.
REQ-019 TRAP: trap=1, trap_cause held, all control outputs 0; exits only via reset.
REQ-020 retired SHALL increment by 1 (wrapping at 2^CNT_W) on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.

Reset
REQ-021 rst=0 SHALL immediately force state=IDLE, wait counter=0, retired=0, trap_cause=00, hence all outputs 0, regardless of clk or ongoing access.
REQ-022 Reset mid-access SHALL drop mem_req the same cycle; no write or PC update completes.

Configuration
REQ-023 Macro MULTI_CYCLE_CTRL_JAL_EN: defined -> JAL state and op 1101111 supported as REQ-008/015; undefined -> JAL state absent, 1101111 goes to TRAP with trap_cause=01, imm_src for it 00.

Verification
REQ-024 R-type (op=0110011), mem_ready=1 -> states 1,2,7,9,1; reg_write=1 only in ALUWB; retired +1 after 4 cycles.
REQ-025 Load with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB reg_write=1, result_src=01; no trap.
REQ-026 BEQ zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both return to FETCH, retired +1.
REQ-027 MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> TRAP after 16 FETCH cycles, trap=1, trap_cause=10, stays until rst.
REQ-028 op=1111111 -> TRAP after DECODE, trap_cause=01; op=1101111 -> JAL (macro defined) or TRAP cause 01 (undefined).
REQ-029 rst asserted during MEMWRITE with mem_ready=0 -> mem_req/mem_write 0 same cycle, state=0, retired=0.
